// File: rtl/adder_arbiter.sv
// Round-robin scheduler that shares one external combinational adder between
// NUM_REQ requesters. Operands are registered toward the adder, and results are returned tagged with the requester ID.
module adder_arbiter #(
   parameter  int NUM_REQ = 4,
   parameter  int WIDTH   = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   input  logic [NUM_REQ-1:0]       req_cin,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [WIDTH-1:0]         add_a,
   output logic [WIDTH-1:0]         add_b,
   output logic                     add_cin,
   input  logic [WIDTH-1:0]         add_s,
   input  logic                     add_cout,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [ID_W-1:0]          rsp_id,
   output logic [WIDTH-1:0]         rsp_sum,
   output logic                     rsp_cout,
   output logic                     busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]       state_reg;
   logic [ID_W-1:0]  ptr_reg;
   logic [ID_W-1:0]  winner;
   logic [ID_W-1:0]  idx;
   logic             found;
   logic             accept;
   logic [WIDTH-1:0] a_arr [NUM_REQ];
   logic [WIDTH-1:0] b_arr [NUM_REQ];

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign a_arr[gi]     = req_a[gi*WIDTH +: WIDTH];
         assign b_arr[gi]     = req_b[gi*WIDTH +: WIDTH];
         assign req_ready[gi] = accept && (winner == ID_W'(gi));
      end
   endgenerate

   // Scan from the farthest offset down so the nearest valid requester to ptr wins.
   always_comb begin
      winner = ptr_reg;
      found  = 1'b0;
      idx    = ptr_reg;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = ptr_reg + k[ID_W-1:0];
         if (req_valid[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   assign accept = rst_n && (state_reg == IDLE) && found;
   assign busy   = (state_reg != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         ptr_reg   <= '0;
         add_a     <= '0;
         add_b     <= '0;
         add_cin   <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_sum   <= '0;
         rsp_cout  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (found) begin
                  add_a     <= a_arr[winner];
                  add_b     <= b_arr[winner];
                  add_cin   <= req_cin[winner];
                  rsp_id    <= winner;
                  ptr_reg   <= winner + ID_W'(1);
                  state_reg <= CALC;
               end
            end
            CALC: begin
               rsp_sum   <= add_s;
               rsp_cout  <= add_cout;
               rsp_valid <= 1'b1;
               state_reg <= RESP;
            end
            RESP: begin
               if (rsp_valid && rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed results.
module tb_adder_arbiter;

   localparam int N  = 4;
   localparam int W  = 4;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N*W-1:0]  req_a;
   logic [N*W-1:0]  req_b;
   logic [N-1:0]    req_cin = '0;
   logic [N-1:0]    req_ready;
   logic [W-1:0]    add_a, add_b, add_s;
   logic            add_cin, add_cout;
   logic            rsp_valid, rsp_ready = 1'b1;
   logic [IW-1:0]   rsp_id;
   logic [W-1:0]    rsp_sum;
   logic            rsp_cout, busy;
   logic [W:0]      add_full;
   logic [W-1:0]    a_in [N];
   logic [W-1:0]    b_in [N];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int served_q[$];
   int accept_q[$];

   // model state: m_cnt = -1 idle, 0 = computing, >=1 = response pending
   int m_cnt = -1;
   int m_ptr = 0;
   int m_id, m_a, m_b, m_c;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // shared adder lives outside the scheduler
   assign add_full = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
   assign add_s    = add_full[W-1:0];
   assign add_cout = add_full[W];

   always_comb begin
      req_a = '0;
      req_b = '0;
      for (int i = 0; i < N; i++) begin
         req_a[i*W +: W] = a_in[i];
         req_b[i*W +: W] = b_in[i];
      end
   end

   adder_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_cin(req_cin), .req_ready(req_ready), .add_a(add_a), .add_b(add_b),
      .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
      .busy(busy));

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Per-cycle compare against the model, then advance the model across the next edge.
   always @(negedge clk) begin
      int g;
      int s;
      logic [N-1:0] exp_ready;
      if (!rst_n) begin
         chk("rst_req_ready", int'(req_ready), 0);
         chk("rst_busy", int'(busy), 0);
         chk("rst_rsp_valid", int'(rsp_valid), 0);
         m_cnt = -1;
         m_ptr = 0;
      end else begin
         g = -1;
         exp_ready = '0;
         if (m_cnt < 0) begin
            for (int k = 0; k < N; k++)
               if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            if (g >= 0) exp_ready[g] = 1'b1;
         end
         chk("req_ready", int'(req_ready), int'(exp_ready));
         chk("busy", int'(busy), int'(m_cnt >= 0));
         chk("rsp_valid", int'(rsp_valid), int'(m_cnt >= 1));
         if (m_cnt >= 0) begin
            chk("add_a", int'(add_a), m_a);
            chk("add_b", int'(add_b), m_b);
            chk("add_cin", int'(add_cin), m_c);
         end
         if (m_cnt >= 1) begin
            s = m_a + m_b + m_c;
            chk("rsp_id", int'(rsp_id), m_id);
            chk("rsp_sum", int'(rsp_sum), s % (1 << W));
            chk("rsp_cout", int'(rsp_cout), s / (1 << W));
         end
         if (req_ready != '0) accept_q.push_back(cyc);
         if (rsp_valid && rsp_ready) begin
            served_q.push_back(int'(rsp_id));
            $display("[TB] rsp id=%0d sum=%0d cout=%0d cycle=%0d", rsp_id, rsp_sum, rsp_cout, cyc);
         end
         if (m_cnt < 0) begin
            if (g >= 0) begin
               m_id  = g;
               m_a   = int'(a_in[g]);
               m_b   = int'(b_in[g]);
               m_c   = int'(req_cin[g]);
               m_ptr = (g + 1) % N;
               m_cnt = 0;
            end
         end else if (m_cnt == 0) begin
            m_cnt = 1;
         end else if (rsp_ready) begin
            m_cnt = -1;
         end else begin
            m_cnt = m_cnt + 1;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
   endtask

   task automatic wait_grant(input int i, output int gcyc);
      int got = 0;
      gcyc = 0;
      for (int t = 0; t < 20 && got == 0; t++) begin
         @(negedge clk);
         if (req_ready[i]) begin
            got  = 1;
            gcyc = cyc;
            chk("grant_onehot", int'(req_ready), 1 << i);
         end
      end
      chk("grant_seen", got, 1);
      @(posedge clk); #1;
   endtask

   task automatic wait_rsp(input int eid, input int esum, input int ecout, output int rcyc);
      int got = 0;
      rcyc = 0;
      for (int t = 0; t < 20 && got == 0; t++) begin
         @(negedge clk);
         if (rsp_valid) begin
            got  = 1;
            rcyc = cyc;
            chk("lit_rsp_id", int'(rsp_id), eid);
            chk("lit_rsp_sum", int'(rsp_sum), esum);
            chk("lit_rsp_cout", int'(rsp_cout), ecout);
         end
      end
      chk("rsp_seen", got, 1);
   endtask

   task automatic do_req(input int i, input int a, input int b, input int c,
                         input int esum, input int ecout);
      int g, r;
      a_in[i] = W'(a);
      b_in[i] = W'(b);
      req_cin[i] = 1'(c);
      req_valid[i] = 1'b1;
      wait_grant(i, g);
      req_valid[i] = 1'b0;
      wait_rsp(i, esum, ecout, r);
      chk("latency", r - g, 2);
      step(2);
   endtask

   initial begin
      int g, r, h, got;
      for (int i = 0; i < N; i++) begin
         a_in[i] = '0;
         b_in[i] = '0;
      end
      #2 rst_n = 1'b0;
      #1;
      chk("r_req_ready", int'(req_ready), 0);
      chk("r_busy", int'(busy), 0);
      chk("r_rsp_valid", int'(rsp_valid), 0);
      chk("r_add_a", int'(add_a), 0);
      chk("r_add_b", int'(add_b), 0);
      chk("r_add_cin", int'(add_cin), 0);
      chk("r_rsp_id", int'(rsp_id), 0);
      chk("r_rsp_sum", int'(rsp_sum), 0);
      chk("r_rsp_cout", int'(rsp_cout), 0);
      step(2);
      rst_n = 1'b1;
      step(1);

      // single request and overflow cases
      do_req(1, 5, 3, 0, 8, 0);
      do_req(0, 9, 9, 1, 3, 1);
      do_req(2, 15, 0, 1, 0, 1);

      // all four valid from reset: strict rotation, accepts 3 cycles apart
      for (int i = 0; i < N; i++) begin
         a_in[i] = W'(i + 1);
         b_in[i] = W'(2 * i + 7);
         req_cin[i] = 1'(i % 2);
      end
      @(posedge clk); #1;
      rst_n = 1'b0;
      req_valid = 4'b1111;
      served_q.delete();
      accept_q.delete();
      step(2);
      rst_n = 1'b1;
      step(30);
      req_valid = '0;
      step(5);
      chk("rr_count", int'(served_q.size() >= 8), 1);
      if (served_q.size() >= 8 && accept_q.size() >= 8)
         for (int k = 0; k < 8; k++) begin
            chk("rr_order", served_q[k], k % 4);
            if (k > 0) chk("rr_spacing", accept_q[k] - accept_q[k-1], 3);
         end

      // fairness between requesters 0 and 2
      do_reset();
      served_q.delete();
      req_valid = 4'b0101;
      step(16);
      req_valid = '0;
      step(5);
      chk("fair_count", int'(served_q.size() >= 4), 1);
      if (served_q.size() >= 4) begin
         chk("fair_0", served_q[0], 0);
         chk("fair_1", served_q[1], 2);
         chk("fair_2", served_q[2], 0);
         chk("fair_3", served_q[3], 2);
      end

      // backpressure: response held while consumer stalls
      rsp_ready = 1'b0;
      a_in[3] = 4'd7; b_in[3] = 4'd6; req_cin[3] = 1'b1;
      req_valid[3] = 1'b1;
      wait_grant(3, g);
      req_valid[3] = 1'b0;
      a_in[0] = 4'd1; b_in[0] = 4'd2; req_cin[0] = 1'b0;
      req_valid[0] = 1'b1;
      wait_rsp(3, 14, 0, r);
      step(5);
      chk("bp_held_valid", int'(rsp_valid), 1);
      chk("bp_held_sum", int'(rsp_sum), 14);
      rsp_ready = 1'b1;
      @(negedge clk);
      h = cyc;
      chk("bp_hs_ready", int'(req_ready), 0);
      @(negedge clk);
      chk("bp_next_grant", int'(req_ready), 4'b0001);
      chk("bp_gap", cyc - h, 1);
      @(posedge clk); #1;
      req_valid = '0;
      step(6);

      // reset while the adder result is in flight
      a_in[2] = 4'd3; b_in[2] = 4'd4; req_cin[2] = 1'b0;
      req_valid[2] = 1'b1;
      wait_grant(2, g);
      req_valid = 4'b1010;
      chk("calc_busy", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_busy", int'(busy), 0);
      chk("mid_rsp_valid", int'(rsp_valid), 0);
      chk("mid_req_ready", int'(req_ready), 0);
      chk("mid_add_a", int'(add_a), 0);
      chk("mid_add_b", int'(add_b), 0);
      chk("mid_rsp_id", int'(rsp_id), 0);
      served_q.delete();
      step(2);
      rst_n = 1'b1;
      got = 0;
      wait_grant(1, g);
      req_valid[1] = 1'b0;
      step(10);
      req_valid = '0;
      step(5);
      chk("mid_served", int'(served_q.size() >= 1), 1);
      if (served_q.size() >= 1) chk("mid_first_id", served_q[0], 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
Round-robin scheduler that shares one external combinational WIDTH-bit ripple adder between NUM_REQ requesters. It accepts one operand set per grant over a valid/ready handshake and drives the shared adder from registered operands. It captures the sum and carry-out and returns them tagged with the requester ID over a valid/ready response channel. It sits between the Tiny Tapeout pin-mapping logic and the shared adder instance.

Parameters:
NUM_REQ, 4, number of requesters; power of two, 2..8
WIDTH, 4, operand and sum width in bits
ID_W, $clog2(NUM_REQ), requester ID width (derived; not overridden)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester request valid
req_a  input  NUM_REQ*WIDTH  operand A; requester i at bits [i*WIDTH +: WIDTH]
req_b  input  NUM_REQ*WIDTH  operand B, same packing
req_cin  input  NUM_REQ  per-requester carry-in
req_ready  output  NUM_REQ  one-hot grant/accept, combinational
add_a  output  WIDTH  registered operand A to shared adder
add_b  output  WIDTH  registered operand B to shared adder
add_cin  output  1  registered carry-in to shared adder
add_s  input  WIDTH  shared adder sum (combinational from add_a/add_b/add_cin)
add_cout  input  1  shared adder carry-out
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_id  output  ID_W  index of requester served
rsp_sum  output  WIDTH  captured sum
rsp_cout  output  1  captured carry-out
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE. add_a, add_b, add_cin, rsp_sum, rsp_cout, rsp_id, rsp_valid all 0. Round-robin pointer ptr=0. req_ready=0 while in reset.
- FSM states are IDLE, CALC, RESP, and advance only on rising clk.
- IDLE: if any req_valid, winner = first i with req_valid[i] searching ptr, ptr+1, ... modulo NUM_REQ. req_ready[winner]=1 in the same cycle, combinationally; all other bits 0. At the edge: add_a/add_b/add_cin <= winner's operands; rsp_id <= winner; ptr <= (winner+1) mod NUM_REQ; state <= CALC. With no req_valid, stay in IDLE with req_ready=0.
- CALC: req_ready=0. At the edge: rsp_sum <= add_s; rsp_cout <= add_cout; rsp_valid <= 1; state <= RESP.
- RESP: req_ready=0. rsp_valid, rsp_id, rsp_sum and rsp_cout are held stable. On rsp_valid && rsp_ready at the edge: rsp_valid <= 0 and state <= IDLE.
- add_a, add_b and add_cin hold their last values outside IDLE→CALC transfers. They are not cleared after a response.
- Latency: request accepted at edge T; rsp_valid high from edge T+2. Earliest next accept is the cycle after the response handshake, so minimum spacing between accepts is 3 cycles.
- Requester protocol: a requester holds valid and operands until it sees its req_ready. It may deassert valid before a grant; the scheduler then takes no action for it. Changing operands while not granted has no effect.
- Arithmetic: {rsp_cout, rsp_sum} = a + b + cin, modulo 2^(WIDTH+1). The value is taken from the shared adder, not recomputed internally.
- Fairness: a requester that stays valid is served within NUM_REQ grants.
- Simultaneous request and response: requests arriving during CALC/RESP wait. No grant is issued in the same cycle as the response handshake; that grant comes in the following IDLE cycle.
- Reset mid-operation (CALC or RESP): the in-flight result is discarded, no response is issued, and ptr returns to 0.

Test Plan:
- Single request: req1 a=5, b=3, cin=0, rsp_ready=1 → req_ready=0010 at T; rsp_valid at T+2 with rsp_id=1, rsp_sum=8, rsp_cout=0; busy high T+1..T+2.
- Overflow with carry-in: req0 a=9, b=9, cin=1 → rsp_sum=3, rsp_cout=1. Also req2 a=15, b=0, cin=1 → rsp_sum=0, rsp_cout=1.
- All four valid continuously from reset, rsp_ready=1 → rsp_id sequence 0,1,2,3,0,...; successive accepts exactly 3 cycles apart.
- Fairness: req0 and req2 held valid → served order 0,2,0,2; req1 and req3 never granted.
- Backpressure: rsp_ready=0 for 5 cycles during RESP → rsp_valid and payload stable, req_ready=0 throughout. Response completes on the cycle rsp_ready rises, and the next grant follows one cycle later.
- Reset asserted during CALC → all outputs 0 immediately (asynchronous), no rsp_valid after release. First grant after release goes to the lowest-index valid requester.
